// File: rtl/rtc_i2c_slave.sv
// DS1307-style RTC emulated as an I2C slave: 64-byte register file whose time bytes
// are refreshed from the MiSTer RTC vector whenever the bus is idle.
module rtc_i2c_slave #(
  parameter logic [6:0] I2C_ADDR = 7'h68
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        scl,
  input  logic        sda_i,
  output logic        sda_o,
  input  logic [64:0] rtc,
  output logic        busy,
  output logic [3:0]  dbg_state_o
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_IGNORE    = 4'd9
  } state_t;

  state_t      state_q;
  logic        scl_meta_q, scl_sync_q, scl_prev_q;
  logic        sda_meta_q, sda_sync_q, sda_prev_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [5:0]  ptr_q;
  logic        rw_q;
  logic        mack_q;
  logic        sda_o_q;
  logic        load_pend_q;
  logic        rtc_tog_q;
  logic [7:0]  regs_q [64];

  logic scl_rise, scl_fall, start_det, stop_det, rtc_toggle;
  logic unused_rtc;

  assign scl_rise   = scl_sync_q & ~scl_prev_q;
  assign scl_fall   = ~scl_sync_q & scl_prev_q;
  assign start_det  = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop_det   = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
  assign rtc_toggle = rtc[64] ^ rtc_tog_q;
  assign unused_rtc = ^rtc[63:51];

  assign sda_o       = sda_o_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      scl_meta_q  <= 1'b1;
      scl_sync_q  <= 1'b1;
      scl_prev_q  <= 1'b1;
      sda_meta_q  <= 1'b1;
      sda_sync_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= 6'd0;
      rw_q        <= 1'b0;
      mack_q      <= 1'b1;
      sda_o_q     <= 1'b1;
      load_pend_q <= 1'b0;
      rtc_tog_q   <= 1'b0;
      for (int i = 0; i < 64; i++) regs_q[i] <= 8'h00;
    end else begin
      scl_meta_q <= scl;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
      rtc_tog_q  <= rtc[64];

      // Time bytes only change between transactions so a burst read is coherent.
      if (state_q == ST_IDLE && load_pend_q) begin
        if (!regs_q[0][7]) begin
          regs_q[0] <= {regs_q[0][7], rtc[6:0]};
          regs_q[1] <= rtc[15:8];
          regs_q[2] <= {rtc[23], 1'b0, rtc[21:16]};
          regs_q[3] <= {5'd0, rtc[50:48]} + 8'd1;
          regs_q[4] <= rtc[31:24];
          regs_q[5] <= rtc[39:32];
          regs_q[6] <= rtc[47:40];
        end
        load_pend_q <= 1'b0;
      end
      if (rtc_toggle) load_pend_q <= 1'b1;

      if (start_det) begin
        state_q   <= ST_ADDR;
        bit_cnt_q <= 4'd0;
        sda_o_q   <= 1'b1;
      end else if (stop_det) begin
        state_q <= ST_IDLE;
        sda_o_q <= 1'b1;
      end else begin
        case (state_q)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise && bit_cnt_q != 4'd8) begin
              shift_q   <= {shift_q[6:0], sda_sync_q};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              bit_cnt_q <= 4'd0;
              if (state_q == ST_ADDR) begin
                if (shift_q[7:1] == I2C_ADDR) begin
                  rw_q    <= shift_q[0];
                  sda_o_q <= 1'b0;
                  state_q <= ST_ADDR_ACK;
                end else begin
                  state_q <= ST_IGNORE;
                end
              end else if (state_q == ST_PTR) begin
                ptr_q   <= shift_q[5:0];
                sda_o_q <= 1'b0;
                state_q <= ST_PTR_ACK;
              end else begin
                regs_q[ptr_q] <= shift_q;
                ptr_q         <= ptr_q + 6'd1;
                sda_o_q       <= 1'b0;
                state_q       <= ST_WDATA_ACK;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt_q <= 4'd0;
              if (rw_q) begin
                shift_q <= regs_q[ptr_q];
                sda_o_q <= regs_q[ptr_q][7];
                ptr_q   <= ptr_q + 6'd1;
                state_q <= ST_RDATA;
              end else begin
                sda_o_q <= 1'b1;
                state_q <= ST_PTR;
              end
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              sda_o_q   <= 1'b1;
              bit_cnt_q <= 4'd0;
              state_q   <= ST_WDATA;
            end
          end
          ST_RDATA: begin
            if (scl_rise && bit_cnt_q != 4'd8) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_o_q <= 1'b1;
                state_q <= ST_RDATA_ACK;
              end else begin
                sda_o_q <= shift_q[6];
                shift_q <= {shift_q[6:0], 1'b0};
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise) begin
              mack_q <= sda_sync_q;
            end else if (scl_fall) begin
              if (!mack_q) begin
                shift_q   <= regs_q[ptr_q];
                sda_o_q   <= regs_q[ptr_q][7];
                ptr_q     <= ptr_q + 6'd1;
                bit_cnt_q <= 4'd0;
                state_q   <= ST_RDATA;
              end else begin
                sda_o_q <= 1'b1;
                state_q <= ST_IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rtc_i2c_slave.sv
// Bench for rtc_i2c_slave: bit-banged I2C master, table of register write/readback
// vectors, and hand-written sequences for RTC load, wrap, halt, deferral and reset.
module tb_rtc_i2c_slave;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic        scl     = 1'b1;
  logic        sda_i   = 1'b1;
  logic        sda_o;
  logic        busy;
  logic [3:0]  dbg_state;
  logic [64:0] rtc     = '0;

  rtc_i2c_slave #(.I2C_ADDR(7'h68)) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .scl         (scl),
    .sda_i       (sda_i),
    .sda_o       (sda_o),
    .rtc         (rtc),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] rd_buf [8];
  logic mon_en   = 1'b0;
  logic low_seen = 1'b0;

  always @(negedge clk_sys) if (mon_en && !sda_o) low_seen = 1'b1;

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [5];

  logic [7:0] exp_load  [8] = '{8'h45, 8'h30, 8'h12, 8'h04, 8'h25, 8'h12, 8'h24, 8'h00};
  logic [7:0] exp_wrap  [8] = '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] exp_halt  [8] = '{8'h80, 8'h30, 8'h12, 8'h04, 8'h25, 8'h12, 8'h24, 8'h00};
  logic [7:0] exp_old   [8] = '{8'h00, 8'h30, 8'h12, 8'h04, 8'h25, 8'h12, 8'h24, 8'h00};
  logic [7:0] exp_new   [8] = '{8'h59, 8'h07, 8'h23, 8'h07, 8'h31, 8'h01, 8'h99, 8'h00};

  function automatic logic [64:0] mk_rtc(input logic tog, input logic [7:0] s, input logic [7:0] m,
                                         input logic [7:0] h, input logic [2:0] wd, input logic [7:0] d,
                                         input logic [7:0] mo, input logic [7:0] y);
    return {tog, 13'd0, wd, y, mo, d, h, m, s};
  endfunction

  task automatic w(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic i2c_start();
    sda_i = 1'b1; w(5);
    scl   = 1'b1; w(5);
    sda_i = 1'b0; w(5);
    scl   = 1'b0; w(5);
  endtask

  task automatic i2c_stop();
    sda_i = 1'b0; w(5);
    scl   = 1'b1; w(5);
    sda_i = 1'b1; w(10);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    sda_i = b; w(10);
    scl   = 1'b1; w(5);
    r     = sda_o; w(5);
    scl   = 1'b0; w(5);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(mack, r);
  endtask

  task automatic set_ptr(input logic [7:0] p);
    logic a;
    i2c_start();
    write_byte(8'hD0, a); check("addr_w ack", a, 1'b0);
    write_byte(p, a);     check("ptr ack", a, 1'b0);
  endtask

  task automatic write_reg(input logic [7:0] p, input logic [7:0] d);
    logic a;
    set_ptr(p);
    write_byte(d, a); check("wdata ack", a, 1'b0);
    i2c_stop();
  endtask

  task automatic read_from(input logic [7:0] p, input int n);
    logic a;
    set_ptr(p);
    i2c_start();
    write_byte(8'hD1, a); check("addr_r ack", a, 1'b0);
    for (int k = 0; k < n; k++) read_byte(k == n - 1, rd_buf[k]);
    i2c_stop();
  endtask

  task automatic check_rd(input string tag, input int n, input logic [7:0] e [8]);
    for (int k = 0; k < n; k++) check($sformatf("%s byte %0d", tag, k), rd_buf[k], e[k]);
  endtask

  initial begin
    #5ms;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    logic a;
    int k;
    tbl[0] = '{8'h07, 8'h5A, 8'h5A};
    tbl[1] = '{8'h08, 8'h01, 8'h01};
    tbl[2] = '{8'h20, 8'hFF, 8'hFF};
    tbl[3] = '{8'h2A, 8'h69, 8'h69};
    tbl[4] = '{8'h3D, 8'hC3, 8'hC3};

    // Reset state
    w(3);
    check("reset sda_o", sda_o, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset state", dbg_state, 4'd0);
    check("reset ptr", dut.ptr_q, 6'd0);
    rst_n = 1'b1;
    w(5);

    // Load from RTC, then burst read of the time bytes
    rtc = mk_rtc(1'b1, 8'h45, 8'h30, 8'h12, 3'd3, 8'h25, 8'h12, 8'h24);
    w(5);
    read_from(8'h00, 7);
    check_rd("load", 7, exp_load);

    // Single-register write/readback vectors
    for (int i = 0; i < 5; i++) begin
      write_reg(tbl[i].ptr, tbl[i].wdata);
      read_from(tbl[i].ptr, 1);
      check($sformatf("vec %0d readback", i), rd_buf[0], tbl[i].exp);
    end

    // NVRAM write crossing 0x3F -> 0x00
    set_ptr(8'h3E);
    write_byte(8'hAA, a); check("wrap ack0", a, 1'b0);
    write_byte(8'hBB, a); check("wrap ack1", a, 1'b0);
    write_byte(8'hCC, a); check("wrap ack2", a, 1'b0);
    i2c_stop();
    read_from(8'h3E, 3);
    check_rd("wrap", 3, exp_wrap);
    read_from(8'h00, 1);
    check("wrap reg0 low bits", rd_buf[0][6:0], 7'h4C);

    // Clock halt blocks the load
    write_reg(8'h00, 8'h80);
    rtc = mk_rtc(1'b0, 8'h11, 8'h22, 8'h03, 3'd1, 8'h04, 8'h05, 8'h06);
    w(10);
    check("halt pend cleared", dut.load_pend_q, 1'b0);
    read_from(8'h00, 7);
    check_rd("halt", 7, exp_halt);
    write_reg(8'h00, 8'h00);

    // Toggle mid-read: old bytes until STOP, new ones one cycle after
    set_ptr(8'h00);
    i2c_start();
    write_byte(8'hD1, a); check("defer addr ack", a, 1'b0);
    read_byte(1'b0, rd_buf[0]);
    read_byte(1'b0, rd_buf[1]);
    rtc = mk_rtc(1'b1, 8'h59, 8'h07, 8'h23, 3'd6, 8'h31, 8'h01, 8'h99);
    for (int j = 2; j < 7; j++) read_byte(j == 6, rd_buf[j]);
    check_rd("defer old", 7, exp_old);
    check("defer pend held", dut.load_pend_q, 1'b1);
    sda_i = 1'b0; w(5);
    scl   = 1'b1; w(5);
    sda_i = 1'b1;
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk_sys);
      k++;
    end
    check("defer stop seen", busy, 1'b0);
    check("defer reg1 at idle", dut.regs_q[1], 8'h30);
    @(negedge clk_sys);
    check("defer reg1 +1 cycle", dut.regs_q[1], 8'h07);
    check("defer reg0 +1 cycle", dut.regs_q[0], 8'h59);
    w(10);
    read_from(8'h00, 7);
    check_rd("defer new", 7, exp_new);

    // Wrong address is ignored
    low_seen = 1'b0;
    mon_en   = 1'b1;
    i2c_start();
    write_byte(8'hA0, a); check("wrong addr nack", a, 1'b1);
    write_byte(8'h00, a); check("wrong addr data nack", a, 1'b1);
    check("wrong addr state", dbg_state, 4'd9);
    i2c_stop();
    mon_en = 1'b0;
    check("wrong addr sda low seen", low_seen, 1'b0);
    read_from(8'h01, 1);
    check("after wrong addr read", rd_buf[0], 8'h07);

    // Reset while the slave is driving an ACK
    set_ptr(8'h10);
    for (int i = 7; i >= 0; i--) begin
      logic r;
      logic [7:0] dv;
      dv = 8'hE7;
      bit_xfer(dv[i], r);
    end
    check("mid ack sda low", sda_o, 1'b0);
    check("mid ack ptr", dut.ptr_q, 6'h11);
    rst_n = 1'b0;
    #1;
    check("mid ack reset sda", sda_o, 1'b1);
    check("mid ack reset ptr", dut.ptr_q, 6'd0);
    check("mid ack reset busy", busy, 1'b0);
    sda_i = 1'b1;
    w(2);
    scl = 1'b1;
    w(3);
    rst_n = 1'b1;
    w(10);
    read_from(8'h10, 1);
    check("post reset nvram", rd_buf[0], 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
